// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single memory_system request port between two requesters:
//   requester 0 : load/store queue
//   requester 1 : instruction-fetch miss path
// Each accepted request gets a private 4-bit memory tag from a 16-entry
// pool. The tag table remembers the owner and the requester's own id, so a
// memory response can be steered back with the original id restored.
//
// Optional feature (compile-time macro MEM_ARB_RR_EN):
//   defined   : round-robin arbitration; on contention the requester not
//               granted most recently wins; the pointer moves only on a
//               transfer, and reset points it at requester 0.
//   undefined : fixed priority; requester 0 always wins, requester 1 is
//               granted only while r0_valid is low.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   rN_valid/addr/data/rw/id   request N (N=0,1), held until granted
//   rN_grant           combinational accept for request N this cycle
//   rN_rsp_valid/data/id       registered response pulse to requester N
//   mem_addr/data/rw/id/valid  registered request strobe to memory
//   mem_rdata/rid/ready        response from memory (tag in mem_rid)
//   mem_stall          memory cannot accept; blocks grant in the same cycle
//   out_cnt            number of outstanding tags, 0..16
//   err_spurious       sticky; response seen for a tag not outstanding
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int NTAG = 16
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          r0_valid,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_data,
  input  logic          r0_rw,
  input  logic [3:0]    r0_id,
  output logic          r0_grant,
  output logic          r0_rsp_valid,
  output logic [DW-1:0] r0_rsp_data,
  output logic [3:0]    r0_rsp_id,

  input  logic          r1_valid,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_data,
  input  logic          r1_rw,
  input  logic [3:0]    r1_id,
  output logic          r1_grant,
  output logic          r1_rsp_valid,
  output logic [DW-1:0] r1_rsp_data,
  output logic [3:0]    r1_rsp_id,

  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_rw,
  output logic [3:0]    mem_id,
  output logic          mem_valid,
  input  logic [DW-1:0] mem_rdata,
  input  logic [3:0]    mem_rid,
  input  logic          mem_ready,
  input  logic          mem_stall,

  output logic [4:0]    out_cnt,
  output logic          err_spurious
);

  localparam logic [4:0] CNT_FULL = 5'(NTAG);

  // Tag table
  logic [NTAG-1:0] busy;
  logic [NTAG-1:0] owner;             // 0 = requester 0, 1 = requester 1
  logic [3:0]      orig_id [NTAG];

  logic            free_found;
  logic [3:0]      free_tag;
  logic            issue_ok;
  logic            xfer0;
  logic            xfer1;
  logic            xfer;
  logic            rsp_hit;
  logic            rsp_miss;
  logic            rsp_owner;

  // Lowest-index free tag; computed from the table state at the start of
  // the cycle, so a tag freed this cycle only becomes allocatable next cycle.
  always_comb begin
    free_found = 1'b0;
    free_tag   = '0;
    for (int unsigned i = 0; i < NTAG; i++) begin
      if (!busy[i] && !free_found) begin
        free_found = 1'b1;
        free_tag   = 4'(i);
      end
    end
  end

  assign issue_ok = !rst && !mem_stall && (out_cnt < CNT_FULL) && free_found;

`ifdef MEM_ARB_RR_EN
  // Requester that wins the next tie.
  logic rr_prio;

  always_comb begin
    r0_grant = 1'b0;
    r1_grant = 1'b0;
    if (issue_ok) begin
      if (r0_valid && r1_valid) begin
        r0_grant = !rr_prio;
        r1_grant = rr_prio;
      end else begin
        r0_grant = r0_valid;
        r1_grant = r1_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_prio <= 1'b0;
    end else if (xfer) begin
      rr_prio <= xfer0;
    end
  end
`else
  always_comb begin
    r0_grant = 1'b0;
    r1_grant = 1'b0;
    if (issue_ok) begin
      r0_grant = r0_valid;
      r1_grant = r1_valid && !r0_valid;
    end
  end
`endif

  assign xfer0 = r0_valid && r0_grant;
  assign xfer1 = r1_valid && r1_grant;
  assign xfer  = xfer0 || xfer1;

  assign rsp_hit   = mem_ready && busy[mem_rid];
  assign rsp_miss  = mem_ready && !busy[mem_rid];
  assign rsp_owner = owner[mem_rid];

  // Table update. The allocated tag is never busy and the freed tag always
  // is, so the two writes to busy never target the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (xfer) begin
        busy[free_tag]    <= 1'b1;
        owner[free_tag]   <= xfer1;
        orig_id[free_tag] <= xfer1 ? r1_id : r0_id;
      end
      if (rsp_hit) begin
        busy[mem_rid] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= '0;
    end else begin
      case ({xfer, rsp_hit})
        2'b10:   out_cnt <= out_cnt + 5'd1;
        2'b01:   out_cnt <= out_cnt - 5'd1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_rw    <= 1'b0;
      mem_id    <= '0;
    end else begin
      mem_valid <= xfer;
      if (xfer) begin
        mem_addr <= xfer1 ? r1_addr : r0_addr;
        mem_data <= xfer1 ? r1_data : r0_data;
        mem_rw   <= xfer1 ? r1_rw   : r0_rw;
        mem_id   <= free_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r0_rsp_valid <= 1'b0;
      r0_rsp_data  <= '0;
      r0_rsp_id    <= '0;
      r1_rsp_valid <= 1'b0;
      r1_rsp_data  <= '0;
      r1_rsp_id    <= '0;
    end else begin
      r0_rsp_valid <= rsp_hit && !rsp_owner;
      r1_rsp_valid <= rsp_hit && rsp_owner;
      if (rsp_hit && !rsp_owner) begin
        r0_rsp_data <= mem_rdata;
        r0_rsp_id   <= orig_id[mem_rid];
      end
      if (rsp_hit && rsp_owner) begin
        r1_rsp_data <= mem_rdata;
        r1_rsp_id   <= orig_id[mem_rid];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_spurious <= 1'b0;
    end else if (rsp_miss) begin
      err_spurious <= 1'b1;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single `memory_system` request port between two requesters: requester 0 is the load/store queue, requester 1 is the instruction-fetch miss path. The block renames each requester's 4-bit ld/st id to a private memory tag from a 16-entry tag pool. It tracks every outstanding request and steers each memory response back to its originating requester with the original id restored. It sits between the core-side queues and `memory_system`, and it owns the memory stall handshake.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `NTAG`, 16, tag pool size; fixed by the 4-bit memory id

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `rN_valid`  in  1  request N (N=0,1) valid; held until granted
- `rN_addr`  in  AW  request address
- `rN_data`  in  DW  store data
- `rN_rw`  in  1  1=store, 0=load
- `rN_id`  in  4  requester's own id
- `rN_grant`  out  1  combinational; request accepted this cycle
- `rN_rsp_valid`  out  1  response pulse to requester N
- `rN_rsp_data`  out  DW  response data
- `rN_rsp_id`  out  4  original `rN_id`
- `mem_addr`, `mem_data`  out  AW/DW  to memory
- `mem_rw`  out  1  to memory
- `mem_id`  out  4  allocated tag
- `mem_valid`  out  1  one-cycle request strobe
- `mem_rdata`  in  DW  from memory
- `mem_rid`  in  4  tag being completed
- `mem_ready`  in  1  response valid
- `mem_stall`  in  1  memory cannot accept
- `out_cnt`  out  5  outstanding tags, 0..16
- `err_spurious`  out  1  sticky; response for a tag that is not outstanding

## Operation
- **Tag table:** 16 entries of {busy, owner, orig_id}. The free tag chosen is always the lowest-index non-busy entry.
- **Issue eligibility:** issue is allowed in cycle N only when `mem_stall`=0 in cycle N and `out_cnt`<16.
- **Arbitration:** among valid requesters, one winner per cycle (policy under Configuration). Only the winner gets `rN_grant`=1. A transfer occurs on `rN_valid && rN_grant`.
- **On transfer:**
  - Mark the tag busy and record owner and `rN_id`.
  - Register `mem_addr/data/rw/id` from the winner's payload and the tag.
  - Pulse `mem_valid` for exactly one cycle.
- **On `mem_ready`:**
  - Look up `mem_rid`. If busy, drive owner's `rsp_valid/data/id` registered on the next edge and clear busy.
  - If not busy, drop the response and set `err_spurious`.
- **Grant invariant:** grant is never asserted to a requester whose `valid`=0.
- **Reset:** clears table, `out_cnt`, `err_spurious`, and the RR pointer (pointer → requester 0).

## Timing
- **Reset values:** all outputs 0 after the reset edge; `rN_grant`=0 while `rst`=1.
- **Issue latency:** transfer in cycle N → `mem_valid`=1 in cycle N+1 only.
- **Response latency:** `mem_ready` in cycle M → `rN_rsp_valid`=1 in cycle M+1. Both requesters never receive a response in the same cycle (one `mem_ready` per cycle).
- **Stall:**
  - `mem_stall` sampled in N blocks grant in N.
  - Memory must accept any strobe presented in N+1.
  - Stall asserted mid-burst stops issue on the same cycle.
- **Tag free timing:** a tag freed by `mem_ready` in M is allocatable from cycle M+1.
- **Full:** at `out_cnt`=16, no grants. Simultaneous allocate and free in one cycle leaves `out_cnt` unchanged.
- **Wrap:** tags are reused freely. A tag's id may repeat while other tags are outstanding.
- **Reset mid-operation:** outstanding entries are discarded with no responses. A later `mem_ready` for a discarded tag sets `err_spurious`.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin: when both valid, grant goes to the requester not granted most recently.
  - Pointer updates only on a transfer.
- `MEM_ARB_RR_EN` undefined:
  - Fixed priority: requester 0 (LSQ) always wins.
  - Requester 1 is granted only when `r0_valid`=0.

## Test plan
- **Single load:** `r0` load, id=5, addr=0x40, memory returns 0xDEADBEEF on tag 0 two cycles later → `mem_valid` at N+1 with `mem_id`=0; `r0_rsp_valid`, `r0_rsp_id`=5, `r0_rsp_data`=0xDEADBEEF one cycle after `mem_ready`; `out_cnt` 0→1→0.
- **Contention:** both requesters valid 4 cycles → with `MEM_ARB_RR_EN` grants alternate 0,1,0,1; without it, grants 0,0,0,0 and `r1_grant` stays 0.
- **Full:** 16 loads issued, no responses → `out_cnt`=16, no grant on the 17th. Return tag 3 → next grant gets `mem_id`=3.
- **Stall:** `mem_stall`=1 for 3 cycles with `r1_valid` high → no grant, no `mem_valid`. Grant occurs in the first cycle stall is 0.
- **Routing:** `r1` id=2 takes tag 0, `r0` id=2 takes tag 1; responses returned in order tag 1, then tag 0 → `r0_rsp_id`=2 first, then `r1_rsp_id`=2, each with correct data.
- **Spurious and reset:** `mem_ready` with `mem_rid`=9 while idle → `err_spurious`=1, no `rsp_valid`. Reset with 2 outstanding → `out_cnt`=0, `err_spurious`=0.
